// File: rtl/branch_predictor.sv
// Gshare branch predictor with a direct-mapped BTB.
// Lookups are registered (one-cycle latency); resolutions train PHT, GHR and BTB.
package mmm_pkg;
  localparam int XLEN = 32;
  localparam int HLEN = 8;
endpackage

module branch_predictor
  import mmm_pkg::*;
#(
  parameter int BTB_BITS = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            fetch_valid_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic            res_valid_i,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic [HLEN-1:0] res_index_i,
  input  logic [XLEN-1:0] res_target_i,
  input  logic            res_taken_i,
  input  logic            res_mispredict_i,
  output logic            pred_valid_o,
  output logic [XLEN-1:0] pred_pc_o,
  output logic [HLEN-1:0] pred_index_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            pred_taken_o,
  output logic [31:0]     mispredict_cnt_o
);
  localparam int PHT_N = 2 ** HLEN;
  localparam int BTB_N = 2 ** BTB_BITS;
  localparam int TAG_W = XLEN - BTB_BITS - 2;

  logic [1:0]       pht [PHT_N];
  logic [HLEN-1:0]  ghr;
  logic [BTB_N-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [XLEN-1:0]  btb_target [BTB_N];

  logic [HLEN-1:0]     look_idx;
  logic [BTB_BITS-1:0] look_bidx;
  logic [BTB_BITS-1:0] res_bidx;
  logic                look_hit;
  logic                look_taken;
  logic [XLEN-1:0]     look_target;
  logic [1:0]          res_ctr;
  logic                unused_res_bits;

  assign look_idx    = fetch_pc_i[HLEN+1:2] ^ ghr;
  assign look_bidx   = fetch_pc_i[BTB_BITS+1:2];
  assign res_bidx    = res_pc_i[BTB_BITS+1:2];
  assign look_hit    = btb_valid[look_bidx] &&
                       (btb_tag[look_bidx] == fetch_pc_i[XLEN-1:BTB_BITS+2]);
  assign look_taken  = pht[look_idx][1] & look_hit;
  assign look_target = look_taken ? btb_target[look_bidx] : fetch_pc_i + XLEN'(4);
  assign res_ctr     = pht[res_index_i];
  assign unused_res_bits = ^res_pc_i[1:0];

  // Prediction registers; payload holds its last value when no lookup arrives.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pred_valid_o  <= 1'b0;
      pred_pc_o     <= '0;
      pred_index_o  <= '0;
      pred_target_o <= '0;
      pred_taken_o  <= 1'b0;
    end else begin
      pred_valid_o <= fetch_valid_i;
      if (fetch_valid_i) begin
        pred_pc_o     <= fetch_pc_i;
        pred_index_o  <= look_idx;
        pred_target_o <= look_target;
        pred_taken_o  <= look_taken;
      end
    end
  end

  // Resolution training; the lookup above reads the pre-edge state, so no bypass exists.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      ghr              <= '0;
      btb_valid        <= '0;
      mispredict_cnt_o <= '0;
    end else begin
      if (res_valid_i) begin
        if (res_taken_i && res_ctr != 2'b11)
          pht[res_index_i] <= res_ctr + 2'b01;
        else if (!res_taken_i && res_ctr != 2'b00)
          pht[res_index_i] <= res_ctr - 2'b01;
        ghr <= {ghr[HLEN-2:0], res_taken_i};
        if (res_taken_i) btb_valid[res_bidx] <= 1'b1;
        if (res_mispredict_i && mispredict_cnt_o != 32'hFFFF_FFFF)
          mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
      end
    end
  end

  // Tag and target only matter once the valid bit is set, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (res_valid_i && res_taken_i) begin
      btb_tag[res_bidx]    <= res_pc_i[XLEN-1:BTB_BITS+2];
      btb_target[res_bidx] <= res_target_i;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// compared against an array-based behavioural model.
module tb_branch_predictor;
  import mmm_pkg::*;

  localparam int BTB_BITS = 5;
  localparam int PHT_N    = 2 ** HLEN;
  localparam int BTB_N    = 2 ** BTB_BITS;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            fetch_valid_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic            res_valid_i;
  logic [XLEN-1:0] res_pc_i;
  logic [HLEN-1:0] res_index_i;
  logic [XLEN-1:0] res_target_i;
  logic            res_taken_i;
  logic            res_mispredict_i;
  logic            pred_valid_o;
  logic [XLEN-1:0] pred_pc_o;
  logic [HLEN-1:0] pred_index_o;
  logic [XLEN-1:0] pred_target_o;
  logic            pred_taken_o;
  logic [31:0]     mispredict_cnt_o;

  always #5 clk_i = ~clk_i;

  branch_predictor #(.BTB_BITS(BTB_BITS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_index_i(res_index_i),
    .res_target_i(res_target_i), .res_taken_i(res_taken_i),
    .res_mispredict_i(res_mispredict_i),
    .pred_valid_o(pred_valid_o), .pred_pc_o(pred_pc_o), .pred_index_o(pred_index_o),
    .pred_target_o(pred_target_o), .pred_taken_o(pred_taken_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: counters as plain integers, history as an integer, BTB as whole PCs.
  int              pht_m [PHT_N];
  int              ghr_m;
  bit              btb_v_m [BTB_N];
  logic [XLEN-1:0] btb_pc_m [BTB_N];
  logic [XLEN-1:0] btb_tgt_m [BTB_N];
  longint          cnt_m;
  bit              exp_valid, exp_taken;
  logic [XLEN-1:0] exp_pc, exp_tgt;
  int              exp_idx;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PHT_N; i++) pht_m[i] = 1;
    for (int i = 0; i < BTB_N; i++) begin
      btb_v_m[i] = 0;
      btb_pc_m[i] = '0;
      btb_tgt_m[i] = '0;
    end
    ghr_m = 0;
    cnt_m = 0;
    exp_valid = 0; exp_taken = 0; exp_pc = '0; exp_tgt = '0; exp_idx = 0;
  endtask

  task automatic check_all();
    checkOutput("pred_valid", 64'(pred_valid_o), 64'(exp_valid));
    checkOutput("pred_pc", 64'(pred_pc_o), 64'(exp_pc));
    checkOutput("pred_index", 64'(pred_index_o), 64'(exp_idx));
    checkOutput("pred_target", 64'(pred_target_o), 64'(exp_tgt));
    checkOutput("pred_taken", 64'(pred_taken_o), 64'(exp_taken));
    checkOutput("mispredict_cnt", 64'(mispredict_cnt_o), 64'(cnt_m));
  endtask

  // Drive one cycle of lookup/resolution, advance the model, then compare after the edge.
  task automatic applyStimulus(input bit fv, input logic [XLEN-1:0] fpc,
                               input bit rv, input logic [XLEN-1:0] rpc, input int ridx,
                               input logic [XLEN-1:0] rtgt, input bit rtk, input bit rmis);
    int  idx, b, rb;
    bit  hit;
    fetch_valid_i    = fv;
    fetch_pc_i       = fpc;
    res_valid_i      = rv;
    res_pc_i         = rpc;
    res_index_i      = HLEN'(ridx);
    res_target_i     = rtgt;
    res_taken_i      = rtk;
    res_mispredict_i = rmis;
    exp_valid = fv;
    if (fv) begin
      idx = int'((fpc / 4) % PHT_N) ^ ghr_m;
      b   = int'((fpc / 4) % BTB_N);
      hit = btb_v_m[b] && (btb_pc_m[b] / (4 * BTB_N)) == (fpc / (4 * BTB_N));
      exp_taken = hit && (pht_m[idx] >= 2);
      exp_tgt   = exp_taken ? btb_tgt_m[b] : fpc + 4;
      exp_pc    = fpc;
      exp_idx   = idx;
    end
    if (rv) begin
      if (rtk) pht_m[ridx] = (pht_m[ridx] == 3) ? 3 : pht_m[ridx] + 1;
      else     pht_m[ridx] = (pht_m[ridx] == 0) ? 0 : pht_m[ridx] - 1;
      ghr_m = ((ghr_m * 2) + int'(rtk)) % PHT_N;
      if (rtk) begin
        rb = int'((rpc / 4) % BTB_N);
        btb_v_m[rb] = 1;
        btb_pc_m[rb] = rpc;
        btb_tgt_m[rb] = rtgt;
      end
      if (rmis && cnt_m < 64'hFFFF_FFFF) cnt_m++;
    end
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic resolve(input logic [XLEN-1:0] rpc, input int ridx,
                         input logic [XLEN-1:0] rtgt, input bit rtk);
    applyStimulus(0, '0, 1, rpc, ridx, rtgt, rtk, 0);
  endtask

  task automatic lookup(input logic [XLEN-1:0] fpc);
    applyStimulus(1, fpc, 0, '0, 0, '0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle with a lookup presented; outputs must clear at once.
  task automatic do_reset();
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 32'h0000_0abc;
    res_valid_i   = 1'b0;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    applyStimulus(0, '0, 0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    fetch_valid_i = 0; fetch_pc_i = '0; res_valid_i = 0; res_pc_i = '0;
    res_index_i = '0; res_target_i = '0; res_taken_i = 0; res_mispredict_i = 0;
    rst_n_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    do_reset();

    $display("[TB] T1/T2 cold lookup and first training");
    lookup(32'h100);
    checkOutput("t1_valid", 64'(pred_valid_o), 64'd1);
    checkOutput("t1_taken", 64'(pred_taken_o), 64'd0);
    checkOutput("t1_target", 64'(pred_target_o), 64'h104);
    checkOutput("t1_index", 64'(pred_index_o), 64'h40);
    resolve(32'h100, 'h40, 32'h80, 1);
    lookup(32'h100);
    checkOutput("t2_index", 64'(pred_index_o), 64'h41);
    checkOutput("t2_taken", 64'(pred_taken_o), 64'd0);
    checkOutput("t2_target", 64'(pred_target_o), 64'h104);

    $display("[TB] T3 counter saturation");
    do_reset();
    repeat (4) resolve(32'h30, 3, 32'h500, 1);
    lookup(32'h30);
    checkOutput("t3_sat_hi_index", 64'(pred_index_o), 64'd3);
    checkOutput("t3_sat_hi_taken", 64'(pred_taken_o), 64'd1);
    checkOutput("t3_sat_hi_target", 64'(pred_target_o), 64'h500);
    repeat (5) resolve(32'h30, 3, 32'h0, 0);
    resolve(32'h308, 3, 32'h600, 1);
    lookup(32'h308);
    checkOutput("t3_sat_lo_index", 64'(pred_index_o), 64'd3);
    checkOutput("t3_sat_lo_taken", 64'(pred_taken_o), 64'd0);
    checkOutput("t3_sat_lo_target", 64'(pred_target_o), 64'h30c);

    $display("[TB] T4 BTB aliasing");
    do_reset();
    resolve(32'h100, 'h43, 32'h80, 1);
    resolve(32'h100 + (4 << BTB_BITS), 'h43, 32'h200, 1);
    lookup(32'h100);
    checkOutput("t4_index", 64'(pred_index_o), 64'h43);
    checkOutput("t4_taken", 64'(pred_taken_o), 64'd0);
    checkOutput("t4_target", 64'(pred_target_o), 64'h104);

    $display("[TB] T5 same-cycle lookup and update");
    do_reset();
    resolve(32'h100, 'h40, 32'h80, 1);
    repeat (HLEN) resolve(32'h0, 'h7f, 32'h0, 0);
    applyStimulus(1, 32'h100, 1, 32'h100, 'h40, 32'h80, 0, 1);
    checkOutput("t5_old_taken", 64'(pred_taken_o), 64'd1);
    checkOutput("t5_old_target", 64'(pred_target_o), 64'h80);
    lookup(32'h100);
    checkOutput("t5_new_taken", 64'(pred_taken_o), 64'd0);
    checkOutput("t5_new_target", 64'(pred_target_o), 64'h104);

    $display("[TB] random traffic with mid-stream reset");
    for (int n = 0; n < 1600; n++) begin
      logic [XLEN-1:0] fpc, rpc, rtgt;
      int ridx;
      if (n == 800) begin
        do_reset();
        lookup(32'h100);
        checkOutput("t6_taken", 64'(pred_taken_o), 64'd0);
        checkOutput("t6_target", 64'(pred_target_o), 64'h104);
        checkOutput("t6_cnt", 64'(mispredict_cnt_o), 64'd0);
      end
      fpc  = XLEN'(($urandom_range(0, 3) << (BTB_BITS + 2)) | ($urandom_range(0, 31) << 2));
      rpc  = XLEN'(($urandom_range(0, 3) << (BTB_BITS + 2)) | ($urandom_range(0, 31) << 2));
      rtgt = XLEN'($urandom) & ~32'h3;
      ridx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PHT_N - 1))
                                         : (int'((rpc / 4) % PHT_N) ^ ghr_m);
      applyStimulus(bit'($urandom_range(0, 3) != 0), fpc,
                    bit'($urandom_range(0, 1)), rpc, ridx, rtgt,
                    bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
    end

    fetch_valid_i = 0;
    res_valid_i = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
